// File: rtl/muldiv_sequencer_if.sv
// Handshake and result bundle between the E-stage pipeline and the mult/div sequencer.
// Latency: none (wires only).
// Backpressure: stallD is the only flow-control signal and it is produced by the sequencer.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             startE;
    logic [1:0]       opE;
    logic [WIDTH-1:0] srcaE;
    logic [WIDTH-1:0] srcbE;
    logic             hiweE;
    logic             loweE;
    logic             hilouseD;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stallD;

    // Pipeline side: issues operations and mthi/mtlo, observes HI/LO and stall
    modport master (
        output startE, opE, srcaE, srcbE, hiweE, loweE, hilouseD,
        input  hi, lo, busy, stallD
    );

    // Sequencer side
    modport slave (
        input  startE, opE, srcaE, srcbE, hiweE, loweE, hilouseD,
        output hi, lo, busy, stallD
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers (mult, multu, div, divu, mthi, mtlo).
// Latency: WIDTH+1 cycles busy after the start edge; HI/LO written on the edge leaving FIX.
// Backpressure: stallD holds F/D while a HI/LO user sits in D during an operation; new work is ignored while busy.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    muldiv_sequencer_if.slave    bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [1:0]           op_q, op_d;
    // Multiplicand magnitude for multiplies, divisor magnitude for divides
    logic [WIDTH-1:0]     opa_q, opa_d;
    // Multiply: {partial product, remaining multiplier}; divide: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    // Raw operand sign bits; only honoured at FIX for signed ops
    logic                 neg_q, neg_d;
    logic                 dneg_q, dneg_d;
    logic                 bzero_q, bzero_d;
    logic [WIDTH-1:0]     srca_q, srca_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    // Operand conditioning at start
    logic                 signed_op;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;

    // Iteration step datapaths
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_diff;
    logic [2*WIDTH-1:0]   div_next;

    // Sign correction at FIX
    logic                 fix_signed;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    assign signed_op = ~bus.opE[0];
    assign a_neg     = signed_op & bus.srcaE[WIDTH-1];
    assign b_neg     = signed_op & bus.srcbE[WIDTH-1];
    assign a_mag     = a_neg ? (~bus.srcaE + WIDTH'(1)) : bus.srcaE;
    assign b_mag     = b_neg ? (~bus.srcbE + WIDTH'(1)) : bus.srcbE;

    // Shift-add multiply step: add multiplicand when the current multiplier bit is set, then shift right
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opa_q : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide step: shift in next dividend bit, subtract divisor when it fits
    assign div_ge   = acc_q[2*WIDTH-1:WIDTH-1] >= {1'b0, opa_q};
    assign div_diff = acc_q[2*WIDTH-2:WIDTH-1] - opa_q;
    assign div_next = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                             : {acc_q[2*WIDTH-2:0], 1'b0};

    // Quotient/product sign follows operand sign mismatch; remainder follows the dividend
    assign fix_signed = ~op_q[0];
    assign prod_fix   = (fix_signed & neg_q) ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
    assign quo_fix    = (fix_signed & neg_q) ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
    assign rem_fix    = (fix_signed & dneg_q) ? (~acc_q[2*WIDTH-1:WIDTH] + WIDTH'(1))
                                              : acc_q[2*WIDTH-1:WIDTH];

    // Sequencer state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: one start in IDLE, WIDTH iteration cycles, one correction cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.startE) state_d = RUN;
            RUN:     if (count_q == LAST_STEP) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and HI/LO next values; start beats mthi/mtlo, everything is ignored while busy
    always_comb begin
        count_d = count_q;
        op_d    = op_q;
        opa_d   = opa_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        dneg_d  = dneg_q;
        bzero_d = bzero_q;
        srca_d  = srca_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (bus.startE) begin
                    count_d = '0;
                    op_d    = bus.opE;
                    opa_d   = bus.opE[1] ? b_mag : a_mag;
                    acc_d   = {{WIDTH{1'b0}}, (bus.opE[1] ? a_mag : b_mag)};
                    neg_d   = bus.srcaE[WIDTH-1] ^ bus.srcbE[WIDTH-1];
                    dneg_d  = bus.srcaE[WIDTH-1];
                    bzero_d = (bus.srcbE == '0);
                    srca_d  = bus.srcaE;
                end else begin
                    if (bus.hiweE) hi_d = bus.srcaE;
                    if (bus.loweE) lo_d = bus.srcaE;
                end
            end
            RUN: begin
                count_d = count_q + CW'(1);
                acc_d   = op_q[1] ? div_next : mul_next;
            end
            FIX: begin
                if (!op_q[1]) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (bzero_q) begin
                    hi_d = srca_q;
                    lo_d = {WIDTH{1'b1}};
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: ;
        endcase
    end

    // Datapath and HI/LO registers; reset abandons any operation and clears HI/LO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            op_q    <= '0;
            opa_q   <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            dneg_q  <= 1'b0;
            bzero_q <= 1'b0;
            srca_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            count_q <= count_d;
            op_q    <= op_d;
            opa_q   <= opa_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            dneg_q  <= dneg_d;
            bzero_q <= bzero_d;
            srca_q  <= srca_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;
    assign bus.busy   = (state_q != IDLE);
    assign bus.stallD = bus.hilouseD & (bus.busy | bus.startE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table, multi-cycle corner sequences,
// and randomized operations against an arithmetic reference model.
module tb_muldiv_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_sequencer_if #(.WIDTH(32)) bus ();

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: signed/unsigned 64-bit arithmetic, with the divide-by-zero convention
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa, sb, sp, sq, sr;
        logic [63:0] ua, ub, up, uq, ur;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (op)
            2'b00: begin sp = sa * sb; return sp; end
            2'b01: begin up = ua * ub; return up; end
            2'b10: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                sq = sa / sb;
                sr = sa % sb;
                return {sr[31:0], sq[31:0]};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    // Issue one operation from IDLE (called away from the clock edge) and follow it to completion.
    // mt = {hiweE, loweE} asserted alongside startE; those writes must be dropped.
    task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic huse, input logic [1:0] mt,
                         input logic [31:0] ehi, input logic [31:0] elo);
        logic [31:0] h0, l0;
        int n;
        bit hold_ok, stall_ok;
        h0 = bus.hi;
        l0 = bus.lo;
        bus.opE      = op;
        bus.srcaE    = a;
        bus.srcbE    = b;
        bus.hilouseD = huse;
        bus.hiweE    = mt[1];
        bus.loweE    = mt[0];
        bus.startE   = 1'b1;
        #1;
        stall_ok = (bus.stallD === huse);
        @(posedge clk);
        #1;
        bus.startE = 1'b0;
        bus.hiweE  = 1'b0;
        bus.loweE  = 1'b0;
        n = 0;
        hold_ok = 1'b1;
        while (bus.busy === 1'b1 && n < 100) begin
            if (bus.hi !== h0 || bus.lo !== l0) hold_ok = 1'b0;
            if (bus.stallD !== huse) stall_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.stallD !== 1'b0) stall_ok = 1'b0;
        chk({name, "_busy_cycles"}, 64'(n), 64'd33);
        chk({name, "_hilo"}, {bus.hi, bus.lo}, {ehi, elo});
        chk({name, "_hold"}, 64'(hold_ok), 64'd1);
        chk({name, "_stall"}, 64'(stall_ok), 64'd1);
        bus.hilouseD = 1'b0;
    endtask

    initial begin
        int n;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        logic [63:0] exp;

        vt[0]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vt[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vt[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vt[3]  = '{2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
        vt[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vt[5]  = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vt[6]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vt[7]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vt[8]  = '{2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        vt[9]  = '{2'b00, 32'h00010000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFF0000};
        vt[10] = '{2'b01, 32'h00010000, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000};

        bus.startE   = 1'b0;
        bus.opE      = 2'b00;
        bus.srcaE    = '0;
        bus.srcbE    = '0;
        bus.hiweE    = 1'b0;
        bus.loweE    = 1'b0;
        bus.hilouseD = 1'b0;
        reset        = 1'b0;

        // Reset state; stallD still follows hilouseD & startE during reset
        #1;
        bus.hilouseD = 1'b1;
        bus.startE   = 1'b1;
        #1;
        chk("reset_stall_start", 64'(bus.stallD), 64'd1);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_hilo", {bus.hi, bus.lo}, 64'h0);
        bus.startE = 1'b0;
        #1;
        chk("reset_stall_idle", 64'(bus.stallD), 64'd0);
        bus.hilouseD = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // mtlo alone, then mthi and mtlo together
        bus.srcaE = 32'h12345678;
        bus.loweE = 1'b1;
        @(posedge clk);
        #1;
        bus.loweE = 1'b0;
        chk("mtlo", {bus.hi, bus.lo}, {32'h0, 32'h12345678});
        bus.srcaE = 32'hA5A5C3C3;
        bus.hiweE = 1'b1;
        bus.loweE = 1'b1;
        @(posedge clk);
        #1;
        bus.hiweE = 1'b0;
        bus.loweE = 1'b0;
        chk("mthi_mtlo", {bus.hi, bus.lo}, {32'hA5A5C3C3, 32'hA5A5C3C3});

        // Directed table; odd entries also exercise stallD, entry 2 adds dropped mthi/mtlo
        for (int i = 0; i < 11; i++) begin
            do_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, 1'(i % 2),
                  (i == 2) ? 2'b11 : 2'b00, vt[i].ehi, vt[i].elo);
        end

        // mthi/mtlo/startE while busy are ignored and do not extend the operation
        bus.opE    = 2'b01;
        bus.srcaE  = 32'd6;
        bus.srcbE  = 32'd7;
        bus.startE = 1'b1;
        @(posedge clk);
        #1;
        bus.startE = 1'b0;
        n = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            n++;
        end
        bus.hiweE  = 1'b1;
        bus.loweE  = 1'b1;
        bus.startE = 1'b1;
        bus.opE    = 2'b11;
        bus.srcaE  = 32'hDEADBEEF;
        bus.srcbE  = 32'h0;
        @(posedge clk);
        #1;
        n++;
        bus.hiweE  = 1'b0;
        bus.loweE  = 1'b0;
        bus.startE = 1'b0;
        chk("busy_mt_ignored", {bus.hi, bus.lo}, {32'h0000FFFF, 32'hFFFF0000});
        while (bus.busy === 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("busy_start_ignored_cycles", 64'(n), 64'd33);
        chk("busy_start_ignored_hilo", {bus.hi, bus.lo}, {32'h0, 32'd42});

        // Asynchronous reset at RUN cycle 10 abandons the multiply and clears HI/LO
        bus.opE      = 2'b00;
        bus.srcaE    = 32'hFFFFFFFF;
        bus.srcbE    = 32'hFFFFFFFF;
        bus.startE   = 1'b1;
        @(posedge clk);
        #1;
        bus.startE = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        bus.hilouseD = 1'b1;
        reset = 1'b0;
        #1;
        chk("midrun_reset_busy", 64'(bus.busy), 64'd0);
        chk("midrun_reset_hilo", {bus.hi, bus.lo}, 64'h0);
        chk("midrun_reset_stall", 64'(bus.stallD), 64'd0);
        bus.hilouseD = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        do_op("after_reset_multu", 2'b01, 32'd3, 32'd5, 1'b1, 2'b00, 32'h0, 32'd15);

        // Randomized operations against the reference model
        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1:       rb = $urandom_range(1, 9);
                2:       rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            exp = ref_model(rop, ra, rb);
            do_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, 1'($urandom_range(0, 1)),
                  2'b00, exp[63:32], exp[31:0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
